// File: rtl/dram_resp_assembler_if.sv
// Bundle of the issue, response and record-release signals of the DRAM
// response assembler. The issuing stage, DRAM read channel and downstream Queue
// connect on the master side. The assembler connects on the slave side.
//
// Handshake semantics:
//   issue    : a pair is accepted on a rising edge where req_issue & req_ready.
//              req_issue while !req_ready is a protocol error and is dropped.
//   response : every rsp_valid beat is consumed on the edge it is sampled.
//              There is no back-pressure toward DRAM.
//   release  : DRAM_get is a one-cycle pulse meaning the cnt/cntl outputs hold
//              a new record. hold=1 postpones the next pulse without losing it.
interface dram_resp_assembler_if #(
   parameter int TAG_W  = 5,
   parameter int DATA_W = 512
);
   logic              req_issue;
   logic [TAG_W-1:0]  req_tag;
   logic              req_ready;
   logic              rsp_valid;
   logic [TAG_W-1:0]  rsp_tag;
   logic              rsp_half;
   logic [DATA_W-1:0] rsp_data;
   logic              hold;
   logic              DRAM_get;
   logic [31:0]       cnt_a0, cnt_a1, cnt_a2, cnt_a3;
   logic [63:0]       cnt_b0, cnt_b1, cnt_b2, cnt_b3;
   logic [31:0]       cntl_a0, cntl_a1, cntl_a2, cntl_a3;
   logic [63:0]       cntl_b0, cntl_b1, cntl_b2, cntl_b3;
   logic [TAG_W:0]    outstanding;
   logic              err;

   modport master (
      output req_issue, rsp_valid, rsp_tag, rsp_half, rsp_data, hold,
      input  req_tag, req_ready, DRAM_get,
      input  cnt_a0, cnt_a1, cnt_a2, cnt_a3, cnt_b0, cnt_b1, cnt_b2, cnt_b3,
      input  cntl_a0, cntl_a1, cntl_a2, cntl_a3, cntl_b0, cntl_b1, cntl_b2, cntl_b3,
      input  outstanding, err
   );

   modport slave (
      input  req_issue, rsp_valid, rsp_tag, rsp_half, rsp_data, hold,
      output req_tag, req_ready, DRAM_get,
      output cnt_a0, cnt_a1, cnt_a2, cnt_a3, cnt_b0, cnt_b1, cnt_b2, cnt_b3,
      output cntl_a0, cntl_a1, cntl_a2, cntl_a3, cntl_b0, cntl_b1, cntl_b2, cntl_b3,
      output outstanding, err
   );
endinterface

// File: rtl/dram_resp_assembler.sv
// Re-pairs out-of-order k/l occurrence-line reads per tag and releases the
// complete {cnt, cntl} records strictly in issue order. The Queue matches these
// records with its forward-entry FIFO by position, so order is essential.
module dram_resp_assembler #(
   parameter int TAG_W  = 5,
   parameter int DATA_W = 512
) (
   input  logic                  Clk_32UI,
   input  logic                  reset,
   dram_resp_assembler_if.slave  bus
);
   localparam int             DEPTH = 1 << TAG_W;
   localparam int             PAY_W = 384;
   localparam logic [TAG_W:0] FULL  = (TAG_W + 1)'(DEPTH);

   // Slot storage: payload arrays carry no reset, so only the valid bits do.
   logic [PAY_W-1:0] k_mem [DEPTH];
   logic [PAY_W-1:0] l_mem [DEPTH];
   logic [DEPTH-1:0] k_vld;
   logic [DEPTH-1:0] l_vld;

   logic [TAG_W-1:0] iss_ptr;
   logic [TAG_W-1:0] head_ptr;
   logic [TAG_W:0]   count;

   logic             get_q;
   logic             err_q;
   logic [PAY_W-1:0] k_out;
   logic [PAY_W-1:0] l_out;

   logic             ready;
   logic             issue_ok;
   logic             issue_bad;
   logic [TAG_W-1:0] rsp_dist;
   logic             rsp_live;
   logic             rsp_dup;
   logic             rsp_ok;
   logic             rsp_bad;
   logic             rel;
   logic [PAY_W-1:0] rsp_pay;
   logic             unused_rsp_hi;

   // Bits above the payload carry nothing the Queue uses.
   assign rsp_pay       = bus.rsp_data[PAY_W-1:0];
   assign unused_rsp_hi = ^bus.rsp_data[DATA_W-1:PAY_W];

   // Classify this cycle's issue, response and release from registered state.
   // A beat for the head slot while it is being released finds both valid bits
   // set and is therefore rejected as a duplicate.
   always_comb begin
      ready     = (count != FULL);
      issue_ok  = bus.req_issue & ready;
      issue_bad = bus.req_issue & ~ready;
      rsp_dist  = bus.rsp_tag - head_ptr;
      rsp_live  = ({1'b0, rsp_dist} < count);
      rsp_dup   = bus.rsp_half ? l_vld[bus.rsp_tag] : k_vld[bus.rsp_tag];
      rsp_ok    = bus.rsp_valid & rsp_live & ~rsp_dup;
      rsp_bad   = bus.rsp_valid & ~(rsp_live & ~rsp_dup);
      rel       = (count != '0) & k_vld[head_ptr] & l_vld[head_ptr] & ~bus.hold;
   end

   // Capture accepted response payload into its half of the tagged slot.
   always_ff @(posedge Clk_32UI) begin
      if (rsp_ok) begin
         if (bus.rsp_half) l_mem[bus.rsp_tag] <= rsp_pay;
         else              k_mem[bus.rsp_tag] <= rsp_pay;
      end
   end

   // Track per-slot half presence; release frees the head slot.
   always_ff @(posedge Clk_32UI or posedge reset) begin
      if (reset) begin
         k_vld <= '0;
         l_vld <= '0;
      end else begin
         if (rel) begin
            k_vld[head_ptr] <= 1'b0;
            l_vld[head_ptr] <= 1'b0;
         end
         if (rsp_ok) begin
            if (bus.rsp_half) l_vld[bus.rsp_tag] <= 1'b1;
            else              k_vld[bus.rsp_tag] <= 1'b1;
         end
      end
   end

   // Advance issue/head pointers and the occupancy count.
   always_ff @(posedge Clk_32UI or posedge reset) begin
      if (reset) begin
         iss_ptr  <= '0;
         head_ptr <= '0;
         count    <= '0;
      end else begin
         if (issue_ok) iss_ptr  <= iss_ptr + 1'b1;
         if (rel)      head_ptr <= head_ptr + 1'b1;
         case ({issue_ok, rel})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Load the output record on release; otherwise keep the last record.
   always_ff @(posedge Clk_32UI or posedge reset) begin
      if (reset) begin
         get_q <= 1'b0;
         k_out <= '0;
         l_out <= '0;
      end else begin
         get_q <= rel;
         if (rel) begin
            k_out <= k_mem[head_ptr];
            l_out <= l_mem[head_ptr];
         end
      end
   end

   // Sticky protocol error: overflowing issue, duplicate or stray beat.
   always_ff @(posedge Clk_32UI or posedge reset) begin
      if (reset)                       err_q <= 1'b0;
      else if (issue_bad || rsp_bad)   err_q <= 1'b1;
   end

   assign bus.req_tag     = iss_ptr;
   assign bus.req_ready   = ready;
   assign bus.outstanding = count;
   assign bus.err         = err_q;
   assign bus.DRAM_get    = get_q;

   assign bus.cnt_a0  = k_out[31:0];
   assign bus.cnt_a1  = k_out[63:32];
   assign bus.cnt_a2  = k_out[95:64];
   assign bus.cnt_a3  = k_out[127:96];
   assign bus.cnt_b0  = k_out[191:128];
   assign bus.cnt_b1  = k_out[255:192];
   assign bus.cnt_b2  = k_out[319:256];
   assign bus.cnt_b3  = k_out[383:320];

   assign bus.cntl_a0 = l_out[31:0];
   assign bus.cntl_a1 = l_out[63:32];
   assign bus.cntl_a2 = l_out[95:64];
   assign bus.cntl_a3 = l_out[127:96];
   assign bus.cntl_b0 = l_out[191:128];
   assign bus.cntl_b1 = l_out[255:192];
   assign bus.cntl_b2 = l_out[319:256];
   assign bus.cntl_b3 = l_out[383:320];
endmodule

// File: tb/tb_dram_resp_assembler.sv
// Directed bench for dram_resp_assembler: in-order pairing, reordering,
// full/wrap, hold, protocol errors and asynchronous reset.
module tb_dram_resp_assembler;
   localparam int TAG_W  = 5;
   localparam int DATA_W = 512;
   localparam int REC_W  = 768;

   logic Clk_32UI;
   logic reset;

   dram_resp_assembler_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

   dram_resp_assembler #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .Clk_32UI (Clk_32UI),
      .reset    (reset),
      .bus      (bus)
   );

   int n_vec     = 0;
   int n_miss    = 0;
   int pulse_cnt = 0;

   logic [REC_W-1:0] exp_q[$];

   // Clock
   initial Clk_32UI = 1'b0;
   always #5 Clk_32UI = ~Clk_32UI;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] make_line(input int id, input bit half);
      logic [511:0] ln;
      ln = '1;
      for (int i = 0; i < 4; i++) begin
         ln[32*i +: 32]      = {8'(id), 8'(i), 7'h0, half, 8'h5A};
         ln[128+64*i +: 64]  = {8'(id), 8'(i), 7'h0, half, 32'hDEADBEEF, 8'h77};
      end
      return ln;
   endfunction

   function automatic logic [REC_W-1:0] make_rec(input int id);
      logic [511:0] k;
      logic [511:0] l;
      k = make_line(id, 1'b0);
      l = make_line(id, 1'b1);
      return {l[383:0], k[383:0]};
   endfunction

   // Scoreboard: every DRAM_get pulse must match the oldest expected record.
   always @(negedge Clk_32UI) begin
      if (bus.DRAM_get === 1'b1) begin
         logic [REC_W-1:0] rec;
         logic [REC_W-1:0] obs;
         pulse_cnt++;
         if (exp_q.size() == 0) begin
            check("extra_pulse", 64'd1, 64'd0);
         end else begin
            rec = exp_q.pop_front();
            obs = {bus.cntl_b3, bus.cntl_b2, bus.cntl_b1, bus.cntl_b0,
                   bus.cntl_a3, bus.cntl_a2, bus.cntl_a1, bus.cntl_a0,
                   bus.cnt_b3,  bus.cnt_b2,  bus.cnt_b1,  bus.cnt_b0,
                   bus.cnt_a3,  bus.cnt_a2,  bus.cnt_a1,  bus.cnt_a0};
            for (int h = 0; h < 2; h++) begin
               for (int i = 0; i < 4; i++) begin
                  check($sformatf("rec_h%0d_a%0d", h, i),
                        64'(obs[384*h + 32*i +: 32]), 64'(rec[384*h + 32*i +: 32]));
                  check($sformatf("rec_h%0d_b%0d", h, i),
                        obs[384*h + 128 + 64*i +: 64], rec[384*h + 128 + 64*i +: 64]);
               end
            end
         end
      end
   end

   // Driver tasks
   task automatic drive_idle();
      bus.req_issue = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_tag   = '0;
      bus.rsp_half  = 1'b0;
      bus.rsp_data  = '0;
      bus.hold      = 1'b0;
   endtask

   task automatic issue();
      bus.req_issue = 1'b1;
      @(negedge Clk_32UI);
      bus.req_issue = 1'b0;
   endtask

   task automatic send_beat(input logic [TAG_W-1:0] tag, input bit half, input logic [511:0] data);
      bus.rsp_valid = 1'b1;
      bus.rsp_tag   = tag;
      bus.rsp_half  = half;
      bus.rsp_data  = data;
      @(negedge Clk_32UI);
      bus.rsp_valid = 1'b0;
   endtask

   task automatic apply_reset();
      #2 reset = 1'b1;
      exp_q.delete();
      @(negedge Clk_32UI);
      reset = 1'b0;
   endtask

   task automatic check_pulses(input string tag, input int exp);
      #1 check(tag, 64'(pulse_cnt), 64'(exp));
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 80 && bus.outstanding != 0; i++) @(negedge Clk_32UI);
      check(tag, 64'(bus.outstanding), 64'd0);
      @(negedge Clk_32UI);
   endtask

   initial begin
      logic [511:0] k;
      logic [511:0] l;
      int base;

      // Reset state
      reset = 1'b1;
      drive_idle();
      @(negedge Clk_32UI);
      @(negedge Clk_32UI);
      check("rst_get",   64'(bus.DRAM_get), 64'd0);
      check("rst_tag",   64'(bus.req_tag), 64'd0);
      check("rst_ready", 64'(bus.req_ready), 64'd1);
      check("rst_outst", 64'(bus.outstanding), 64'd0);
      check("rst_err",   64'(bus.err), 64'd0);
      check("rst_cnt_a0", 64'(bus.cnt_a0), 64'd0);
      check("rst_cntl_b3", bus.cntl_b3, 64'd0);
      reset = 1'b0;
      @(negedge Clk_32UI);

      // Single item, in order
      check("t1_tag", 64'(bus.req_tag), 64'd0);
      issue();
      check("t1_outst", 64'(bus.outstanding), 64'd1);
      k = '0; k[31:0] = 32'hA0; k[383:320] = 64'hB3; k[511:384] = '1;
      l = '0; l[31:0] = 32'hC0;
      exp_q.push_back({l[383:0], k[383:0]});
      send_beat(5'd0, 1'b0, k);
      check("t1_no_get_k", 64'(bus.DRAM_get), 64'd0);
      send_beat(5'd0, 1'b1, l);
      check("t1_no_get_1", 64'(bus.DRAM_get), 64'd0);
      @(negedge Clk_32UI);
      check("t1_get",     64'(bus.DRAM_get), 64'd1);
      check("t1_cnt_a0",  64'(bus.cnt_a0), 64'hA0);
      check("t1_cnt_b3",  bus.cnt_b3, 64'hB3);
      check("t1_cntl_a0", 64'(bus.cntl_a0), 64'hC0);
      check("t1_outst0",  64'(bus.outstanding), 64'd0);
      @(negedge Clk_32UI);
      check("t1_get_low", 64'(bus.DRAM_get), 64'd0);
      check("t1_err",     64'(bus.err), 64'd0);
      check_pulses("t1_pulses", 1);

      // Reordering: 2k 2l 1l 0k 1k 0l
      apply_reset();
      base = pulse_cnt;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t2_tag%0d", i), 64'(bus.req_tag), 64'(i));
         exp_q.push_back(make_rec(10 + i));
         issue();
      end
      send_beat(5'd2, 1'b0, make_line(12, 1'b0));
      send_beat(5'd2, 1'b1, make_line(12, 1'b1));
      send_beat(5'd1, 1'b1, make_line(11, 1'b1));
      send_beat(5'd0, 1'b0, make_line(10, 1'b0));
      send_beat(5'd1, 1'b0, make_line(11, 1'b0));
      @(negedge Clk_32UI);
      check("t2_no_get", 64'(bus.DRAM_get), 64'd0);
      check_pulses("t2_early", base);
      send_beat(5'd0, 1'b1, make_line(10, 1'b1));
      check("t2_wait", 64'(bus.DRAM_get), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk_32UI);
         check($sformatf("t2_get%0d", i), 64'(bus.DRAM_get), 64'd1);
      end
      @(negedge Clk_32UI);
      check("t2_get_end", 64'(bus.DRAM_get), 64'd0);
      check("t2_outst",   64'(bus.outstanding), 64'd0);
      check_pulses("t2_pulses", base + 3);

      // Full and wrap
      apply_reset();
      base = pulse_cnt;
      for (int i = 0; i < 32; i++) begin
         check($sformatf("t3_tag%0d", i), 64'(bus.req_tag), 64'(i));
         issue();
      end
      check("t3_full_outst", 64'(bus.outstanding), 64'd32);
      check("t3_full_ready", 64'(bus.req_ready), 64'd0);
      check("t3_err_before", 64'(bus.err), 64'd0);
      issue();
      check("t3_ovf_err",   64'(bus.err), 64'd1);
      check("t3_ovf_outst", 64'(bus.outstanding), 64'd32);
      check("t3_ovf_tag",   64'(bus.req_tag), 64'd0);
      for (int i = 0; i < 32; i++) begin
         exp_q.push_back(make_rec(i));
         send_beat(5'(i), 1'b1, make_line(i, 1'b1));
         send_beat(5'(i), 1'b0, make_line(i, 1'b0));
      end
      drain("t3_drain");
      check("t3_ready", 64'(bus.req_ready), 64'd1);
      check_pulses("t3_pulses32", base + 32);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t3_wrap_tag%0d", i), 64'(bus.req_tag), 64'(i));
         exp_q.push_back(make_rec(32 + i));
         issue();
      end
      for (int i = 4; i >= 0; i--) begin
         send_beat(5'(i), 1'b0, make_line(32 + i, 1'b0));
         send_beat(5'(i), 1'b1, make_line(32 + i, 1'b1));
      end
      drain("t3_drain_wrap");
      check_pulses("t3_pulses37", base + 37);

      // Hold
      apply_reset();
      base = pulse_cnt;
      bus.hold = 1'b1;
      exp_q.push_back(make_rec(20));
      issue();
      send_beat(5'd0, 1'b0, make_line(20, 1'b0));
      send_beat(5'd0, 1'b1, make_line(20, 1'b1));
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk_32UI);
         check($sformatf("t4_held%0d", i), 64'(bus.DRAM_get), 64'd0);
         check($sformatf("t4_stable%0d", i), 64'(bus.cnt_a0), 64'd0);
      end
      check("t4_outst", 64'(bus.outstanding), 64'd1);
      bus.hold = 1'b0;
      @(negedge Clk_32UI);
      check("t4_get", 64'(bus.DRAM_get), 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk_32UI);
         check($sformatf("t4_no_dup%0d", i), 64'(bus.DRAM_get), 64'd0);
      end
      check_pulses("t4_pulses", base + 1);

      // Errors: stray tag, then duplicate half
      apply_reset();
      base = pulse_cnt;
      issue();
      issue();
      send_beat(5'd5, 1'b0, make_line(99, 1'b0));
      check("t5_stray_err", 64'(bus.err), 64'd1);
      apply_reset();
      exp_q.push_back(make_rec(50));
      issue();
      send_beat(5'd0, 1'b0, make_line(50, 1'b0));
      check("t5_clean_err", 64'(bus.err), 64'd0);
      send_beat(5'd0, 1'b0, make_line(99, 1'b0));
      check("t5_dup_err", 64'(bus.err), 64'd1);
      send_beat(5'd0, 1'b1, make_line(50, 1'b1));
      drain("t5_drain");
      check_pulses("t5_pulses", base + 1);

      // Asynchronous reset mid-operation
      apply_reset();
      base = pulse_cnt;
      for (int i = 0; i < 3; i++) issue();
      send_beat(5'd1, 1'b0, make_line(60, 1'b0));
      check("t6_pre_outst", 64'(bus.outstanding), 64'd3);
      check("t6_pre_tag",   64'(bus.req_tag), 64'd3);
      #2 reset = 1'b1;
      #1;
      check("t6_outst", 64'(bus.outstanding), 64'd0);
      check("t6_get",   64'(bus.DRAM_get), 64'd0);
      check("t6_tag",   64'(bus.req_tag), 64'd0);
      check("t6_ready", 64'(bus.req_ready), 64'd1);
      @(negedge Clk_32UI);
      reset = 1'b0;
      @(negedge Clk_32UI);
      check("t6_err_clr", 64'(bus.err), 64'd0);
      send_beat(5'd1, 1'b1, make_line(60, 1'b1));
      check("t6_stale_err", 64'(bus.err), 64'd1);
      repeat (3) @(negedge Clk_32UI);
      check("t6_outst_after", 64'(bus.outstanding), 64'd0);
      check_pulses("t6_pulses", base);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      n_miss++;
      $display("FAIL timeout: got running expected finished");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
